freq_cal_controller: RTL and testbench

Closed-loop calibration sequencer for the ring-oscillator frequency regulator. It measures the oscillator frequency by counting synchronized ring ticks over a fixed window of reference clocks. It compares each measurement against the programmed frequency band and steps the divider setting up or down until the band is held for a required number of consecutive windows. It sits between the top-level configuration registers (init, fmin, fmax, setperiod) and the regulator datapath, which consumes adjusteddiv.

---
 rtl/freq_ctrl_pkg.sv | 24 ++
 rtl/tick_window_counter.sv | 43 ++++
 rtl/freq_cal_controller.sv | 177 +++++++++++++++++
 tb/tb_freq_cal_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/freq_ctrl_pkg.sv
// Shared types and helpers for the ring-oscillator frequency calibration sequencer.
package freq_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMeasure,
    StEval,
    StAdjust,
    StLocked,
    StFail
  } state_e;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_e;

  // All-ones value for a given width, used as the saturation ceiling.
  function automatic logic [31:0] sat_max(input int unsigned width);
    return (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/tick_window_counter.sv
// Counts synchronized ring ticks over a fixed window of reference-clock cycles.
module tick_window_counter
  import freq_ctrl_pkg::*;
#(
  parameter int unsigned WINDOW = 256,
  parameter int unsigned WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             ring_tick,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  localparam int unsigned     CW      = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CW-1:0]   LastCyc = CW'(WINDOW - 1);
  localparam logic [WIDTH-1:0] SatMax = WIDTH'(sat_max(WIDTH));

  logic [CW-1:0]    cyc_q;
  logic [WIDTH-1:0] acc_q;

  // count includes the current cycle's tick so it is complete when done is high.
  always_comb begin
    done  = run && (cyc_q == LastCyc);
    count = (ring_tick && (acc_q != SatMax)) ? acc_q + WIDTH'(1) : acc_q;
  end

  // Idle or a finished window clears, so back-to-back windows restart cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
      acc_q <= '0;
    end else if (!run || done) begin
      cyc_q <= '0;
      acc_q <= '0;
    end else begin
      cyc_q <= cyc_q + CW'(1);
      acc_q <= count;
    end
  end

endmodule

// File: rtl/freq_cal_controller.sv
// Closed-loop calibration sequencer: measures ring frequency per window and steps
// the divider until the band is held for LOCK_COUNT consecutive windows.
module freq_cal_controller
  import freq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned WINDOW     = 256,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned MAX_ITER   = 64
) (
  input  logic             clk_frequency,
  input  logic             rst_frequency,
  input  logic             init,
  input  logic             ring_tick,
  input  logic [WIDTH-1:0] fmin,
  input  logic [WIDTH-1:0] fmax,
  input  logic [WIDTH-1:0] setperiod,
  output logic [WIDTH-1:0] adjusteddiv,
  output logic             increment,
  output logic             decrement,
  output logic [WIDTH-1:0] meas_count,
  output logic             busy,
  output logic             locked,
  output logic             fail
);

  localparam int unsigned      IW     = (MAX_ITER > 0) ? $clog2(MAX_ITER + 1) : 1;
  localparam int unsigned      GW     = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] SatMax = WIDTH'(sat_max(WIDTH));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] adj_q, adj_d;
  logic [WIDTH-1:0] meas_q, meas_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic [GW-1:0]    good_q, good_d;
  logic             inc_q, inc_d;
  logic             dec_q, dec_d;

  logic             win_run;
  logic             win_done;
  logic [WIDTH-1:0] win_count;

  logic [WIDTH-1:0] eval_val;
  logic             too_slow;
  logic             too_fast;
  logic             in_band;
  dir_e             dir;
  logic             step_ok;

  assign win_run = (state_q == StMeasure) || (state_q == StLocked);

  tick_window_counter #(
    .WINDOW(WINDOW),
    .WIDTH (WIDTH)
  ) u_win (
    .clk      (clk_frequency),
    .rst      (rst_frequency),
    .run      (win_run),
    .ring_tick(ring_tick),
    .done     (win_done),
    .count    (win_count)
  );

  // LOCKED judges its window as it closes; EVAL judges the latched count.
  always_comb begin
    eval_val = (state_q == StLocked) ? win_count : meas_q;
    too_slow = eval_val < fmin;
    too_fast = eval_val > fmax;
    in_band  = !too_slow && !too_fast;
    dir      = too_slow ? DIR_DOWN : DIR_UP;
    step_ok  = (iter_q != IW'(MAX_ITER)) &&
               ((dir == DIR_DOWN) ? (adj_q != '0) : (adj_q != SatMax));
  end

  // The step is registered on entry to ADJUST so the pulse and the new divider
  // are visible during ADJUST; no pulse there means the step was refused.
  always_comb begin
    state_d = state_q;
    adj_d   = adj_q;
    meas_d  = meas_q;
    iter_d  = iter_q;
    good_d  = good_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;

    if (!init) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: state_d = StLoad;
        StLoad: begin
          adj_d   = setperiod;
          iter_d  = '0;
          good_d  = '0;
          state_d = (fmin > fmax) ? StFail : StMeasure;
        end
        StMeasure: begin
          if (win_done) begin
            meas_d  = win_count;
            state_d = StEval;
          end
        end
        StEval: begin
          if (in_band) begin
            good_d  = good_q + GW'(1);
            state_d = ((good_q + GW'(1)) == GW'(LOCK_COUNT)) ? StLocked : StMeasure;
          end else begin
            good_d  = '0;
            state_d = StAdjust;
            if (step_ok) begin
              iter_d = iter_q + IW'(1);
              if (dir == DIR_DOWN) begin
                adj_d = adj_q - WIDTH'(1);
                dec_d = 1'b1;
              end else begin
                adj_d = adj_q + WIDTH'(1);
                inc_d = 1'b1;
              end
            end
          end
        end
        StAdjust: state_d = (inc_q || dec_q) ? StMeasure : StFail;
        StLocked: begin
          if (win_done) begin
            meas_d = win_count;
            if (!in_band) begin
              good_d  = '0;
              state_d = StAdjust;
              if (step_ok) begin
                iter_d = iter_q + IW'(1);
                if (dir == DIR_DOWN) begin
                  adj_d = adj_q - WIDTH'(1);
                  dec_d = 1'b1;
                end else begin
                  adj_d = adj_q + WIDTH'(1);
                  inc_d = 1'b1;
                end
              end
            end
          end
        end
        StFail: state_d = StFail;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_frequency or posedge rst_frequency) begin
    if (rst_frequency) begin
      state_q <= StIdle;
      adj_q   <= '0;
      meas_q  <= '0;
      iter_q  <= '0;
      good_q  <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adj_q   <= adj_d;
      meas_q  <= meas_d;
      iter_q  <= iter_d;
      good_q  <= good_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
    end
  end

  assign adjusteddiv = adj_q;
  assign meas_count  = meas_q;
  assign increment   = inc_q;
  assign decrement   = dec_q;
  assign busy        = (state_q == StLoad) || (state_q == StMeasure) ||
                       (state_q == StEval) || (state_q == StAdjust);
  assign locked      = (state_q == StLocked);
  assign fail        = (state_q == StFail);

endmodule

// File: tb/tb_freq_cal_controller.sv
// Directed bench for freq_cal_controller with a scoreboard of expected divider steps.
module tb_freq_cal_controller;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned WINDOW     = 16;
  localparam int unsigned LOCK_COUNT = 2;
  localparam int unsigned MAX_ITER   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             init = 1'b0;
  logic             ring_tick = 1'b0;
  logic [WIDTH-1:0] fmin = '0;
  logic [WIDTH-1:0] fmax = '0;
  logic [WIDTH-1:0] setperiod = '0;
  logic [WIDTH-1:0] adjusteddiv;
  logic             increment;
  logic             decrement;
  logic [WIDTH-1:0] meas_count;
  logic             busy;
  logic             locked;
  logic             fail;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ref_cyc = 0;
  int tick_period = 0;
  int n;

  typedef struct {
    logic             inc;
    logic [WIDTH-1:0] div;
    int               at;
  } pulse_t;
  pulse_t exp_q[$];

  always #5 clk = ~clk;

  freq_cal_controller #(
    .WIDTH     (WIDTH),
    .WINDOW    (WINDOW),
    .LOCK_COUNT(LOCK_COUNT),
    .MAX_ITER  (MAX_ITER)
  ) dut (
    .clk_frequency(clk),
    .rst_frequency(rst),
    .init         (init),
    .ring_tick    (ring_tick),
    .fmin         (fmin),
    .fmax         (fmax),
    .setperiod    (setperiod),
    .adjusteddiv  (adjusteddiv),
    .increment    (increment),
    .decrement    (decrement),
    .meas_count   (meas_count),
    .busy         (busy),
    .locked       (locked),
    .fail         (fail)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Advance one clock, drive the tick pattern, and score any divider pulse.
  task automatic step();
    pulse_t e;
    @(posedge clk);
    #1;
    cyc++;
    ring_tick = (tick_period != 0) && ((cyc % tick_period) == 0);
    if (increment || decrement) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_dir_inc", 32'(increment), 32'(e.inc));
        check("pulse_dir_dec", 32'(decrement), 32'(!e.inc));
        check("pulse_div", 32'(adjusteddiv), 32'(e.div));
        if (e.at >= 0) check("pulse_time", 32'(cyc - ref_cyc), 32'(e.at));
      end
    end
  endtask

  initial begin
    // Reset state
    step();
    check("rst_div", 32'(adjusteddiv), 32'd0);
    check("rst_meas", 32'(meas_count), 32'd0);
    check("rst_flags", {27'd0, increment, decrement, busy, locked, fail}, 32'd0);
    rst = 1'b0;
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // Nominal lock at 8 ticks per window, no adjustment
    fmin = 8'd6; fmax = 8'd10; setperiod = 8'd90; tick_period = 2;
    init = 1'b1;
    step();
    ref_cyc = cyc;
    check("load_busy", 32'(busy), 32'd1);
    n = 0;
    while (!locked && n < 100) begin step(); n++; end
    check("lock_latency", 32'(n), 32'd35);
    check("lock_div", 32'(adjusteddiv), 32'd90);
    check("lock_meas", 32'(meas_count), 32'd8);
    check("lock_busy", 32'(busy), 32'd0);

    // Rate rises while locked: one increment, then re-lock at 8 ticks
    exp_q.push_back('{inc: 1'b1, div: 8'd91, at: -1});
    tick_period = 1;
    n = 0;
    while (locked && n < 60) begin step(); n++; end
    check("unlock_inc", 32'(increment), 32'd1);
    check("unlock_busy", 32'(busy), 32'd1);
    tick_period = 2;
    n = 0;
    while (!locked && n < 100) begin step(); n++; end
    check("relock_latency", 32'(n), 32'd35);
    check("relock_div", 32'(adjusteddiv), 32'd91);
    check("relock_meas", 32'(meas_count), 32'd8);

    // Too fast every window: four increments then MAX_ITER failure
    init = 1'b0;
    step();
    check("abort_idle", {30'd0, busy, locked}, 32'd0);
    check("abort_hold_div", 32'(adjusteddiv), 32'd91);
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back('{inc: 1'b1, div: 8'(90 + k), at: 18 * k});
    end
    setperiod = 8'd90; tick_period = 1; init = 1'b1;
    step();
    ref_cyc = cyc;
    n = 0;
    while (!fail && n < 200) begin step(); n++; end
    check("maxiter_fail_time", 32'(cyc - ref_cyc), 32'd91);
    check("maxiter_div", 32'(adjusteddiv), 32'd94);
    check("maxiter_meas", 32'(meas_count), 32'd16);
    check("maxiter_pending", 32'(exp_q.size()), 32'd0);

    // Too slow from divider 1: step to 0, then refuse to wrap
    init = 1'b0;
    step();
    check("idle_after_fail", 32'(fail), 32'd0);
    exp_q.push_back('{inc: 1'b0, div: 8'd0, at: 18});
    setperiod = 8'd1; tick_period = 0; init = 1'b1;
    step();
    ref_cyc = cyc;
    n = 0;
    while (!fail && n < 200) begin step(); n++; end
    check("wrap_fail_time", 32'(cyc - ref_cyc), 32'd37);
    check("wrap_div", 32'(adjusteddiv), 32'd0);
    check("wrap_meas", 32'(meas_count), 32'd0);
    check("wrap_pending", 32'(exp_q.size()), 32'd0);

    // Inverted band fails straight out of LOAD
    init = 1'b0;
    step();
    fmin = 8'd10; fmax = 8'd6; setperiod = 8'd55; init = 1'b1;
    step();
    check("badband_load", {30'd0, busy, fail}, 32'd2);
    step();
    check("badband_fail", {30'd0, busy, fail}, 32'd1);
    check("badband_div", 32'(adjusteddiv), 32'd55);

    // Single-value band locks
    init = 1'b0;
    step();
    fmin = 8'd8; fmax = 8'd8; setperiod = 8'd20; tick_period = 2; init = 1'b1;
    step();
    n = 0;
    while (!locked && n < 100) begin step(); n++; end
    check("narrow_lock_latency", 32'(n), 32'd35);
    check("narrow_lock_div", 32'(adjusteddiv), 32'd20);

    // init dropped mid-MEASURE holds values; reset mid-window clears them
    init = 1'b0;
    step();
    setperiod = 8'd33; init = 1'b1;
    step();
    repeat (6) step();
    check("mid_busy", 32'(busy), 32'd1);
    init = 1'b0;
    step();
    check("drop_idle", {29'd0, busy, locked, fail}, 32'd0);
    check("drop_hold_div", 32'(adjusteddiv), 32'd33);
    check("drop_hold_meas", 32'(meas_count), 32'd8);
    init = 1'b1;
    step();
    repeat (5) step();
    rst = 1'b1;
    #1;
    check("async_rst_div", 32'(adjusteddiv), 32'd0);
    check("async_rst_meas", 32'(meas_count), 32'd0);
    check("async_rst_flags", {27'd0, increment, decrement, busy, locked, fail}, 32'd0);
    step();
    check("rst_hold_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    init = 1'b0;
    step();
    check("final_idle", {29'd0, busy, locked, fail}, 32'd0);
    check("final_pending", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
